serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial adder: adds two WIDTH-bit operands one bit per clock, LSB first.
- Uses a single full-adder bit cell plus a carry flip-flop.
- Sits downstream of the full-adder cell and consumes its sum/carry each cycle.
- Area-cheap alternative to a ripple adder, for datapaths where latency is acceptable.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- cin  input  1  carry-in; captured on an accepted start.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; holds its value until the next completion.
- carry  output  1  carry-out of the MSB; holds with sum.

Behaviour:
- Clock/reset: one clock (clk). Reset rst_n is synchronous, active-low.
- Reset values: state=IDLE, busy=0, done=0, sum=0, carry=0, bit counter=0, carry FF=0, shift registers=0.
- Reset mid-operation: abort on the next edge with rst_n=0 and return to reset values. No partial result is published.
- States and transitions:
  - IDLE: start=1 at edge T0 → load shift_a=a, shift_b=b, carry FF=cin, cnt=0; go to SHIFT.
  - SHIFT: each edge computes {c,s} = FA(shift_a[0], shift_b[0], carry FF). Then shift_a and shift_b shift right, s enters the MSB of shift_s, carry FF=c, cnt++. When cnt==WIDTH-1 at the edge, go to DONE and copy {carry, sum} from the final c and shift_s.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency: done is high in the cycle after edge T0+WIDTH, i.e. WIDTH+1 edges after start is sampled.
- Throughput: one addition per WIDTH+2 cycles.
- start while busy (SHIFT or DONE): ignored, no queuing. a/b/cin changes during SHIFT have no effect.
- Arithmetic: {carry,sum} = a + b + cin, modulo 2^(WIDTH+1). Unsigned; no saturation.
- Counter width: $clog2(WIDTH). Terminal count WIDTH-1; no wrap beyond it.
- sum/carry are updated only at completion and remain stable in IDLE, SHIFT and DONE otherwise.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined: adds output ovf (1 bit), the two's-complement signed overflow, = carry into MSB XOR carry out of MSB.
  - ovf is captured at completion alongside sum and resets to 0.
  - Needs one extra FF holding the MSB carry-in.
- Undefined: no ovf port and no extra FF. Behaviour is otherwise identical.

Decomposition:
- Shared package serial_adder_pkg:
  - state enum typedef (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - localparam function for counter width.
- Sub-module: the existing fulladder cell (ports a, b, c, sum, carry), instantiated once for the per-bit add.
- FSM, counter and shift registers stay in serial_adder.

Test Plan:
- Reset, then WIDTH=8, a=8'h0F, b=8'h01, cin=0, start 1 cycle → done pulses 9 cycles after start, sum=8'h10, carry=0, busy high for 9 cycles.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, carry=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, carry=1.
- start held high and operands changed to 8'hAA/8'h55 during SHIFT → result still from the first operands; a second op starts only after return to IDLE.
- rst_n=0 for one edge at the 4th SHIFT cycle → busy=0, sum=0, carry=0 next cycle; no done pulse.
- With SERIAL_ADDER_OVF_EN: a=8'h7F, b=8'h01 → sum=8'h80, carry=0, ovf=1. a=8'h80, b=8'h80 → sum=8'h00, carry=1, ovf=1.
- Exhaustive random: 1000 back-to-back ops → {carry,sum} == a+b+cin each time; done never high two consecutive cycles.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder; ovf exists only with SERIAL_ADDER_OVF_EN.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
        input  ovf,
`endif
        input  busy, done, sum, carry
    );

    modport slave (
        input  start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
        output ovf,
`endif
        output busy, done, sum, carry
    );
endinterface

// File: rtl/serial_adder_fulladder.sv
// Single-bit full-adder cell used by the serial adder datapath.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry FF, LSB first, WIDTH+1 cycle latency.
// Optional signed-overflow output enabled with SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] shift_s_q, shift_s_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cff_q, cff_d;
    logic             carry_q, carry_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif
    logic             fa_s, fa_c;

    fulladder u_fa (
        .a     (shift_a_q[0]),
        .b     (shift_b_q[0]),
        .c     (cff_q),
        .sum   (fa_s),
        .carry (fa_c)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        shift_s_d = shift_s_q;
        sum_d     = sum_q;
        cff_d     = cff_q;
        carry_d   = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shift_a_d = bus.a;
                    shift_b_d = bus.b;
                    cff_d     = bus.cin;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                shift_s_d = (shift_s_q >> 1) | {fa_s, {(WIDTH-1){1'b0}}};
                cff_d     = fa_c;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Publish straight from the next-state value so the final bit lands this edge.
                    state_d = DONE;
                    sum_d   = shift_s_d;
                    carry_d = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = cff_q ^ fa_c;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_a_q <= '0;
            shift_b_q <= '0;
            shift_s_q <= '0;
            sum_q     <= '0;
            cff_q     <= 1'b0;
            carry_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            shift_s_q <= shift_s_d;
            sum_q     <= sum_d;
            cff_q     <= cff_d;
            carry_q   <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == DONE);
    assign bus.sum   = sum_q;
    assign bus.carry = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): directed vectors plus back-to-back random ops.
module tb_serial_adder;
    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
        int unsigned  cyc;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];
    logic prev_done = 1'b0;

    function automatic logic signed_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] s);
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] s, input logic c, input logic o,
                            input int unsigned dcyc, input string name);
        exp_t e;
        e.sum = s; e.carry = c; e.ovf = o; e.cyc = dcyc; e.name = name;
        q.push_back(e);
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy still high after %0d cycles, required low", n);
        end
    endtask

    // One-cycle start pulse; t0 is the cycle count just after the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input bit push, input logic [W-1:0] es, input logic ec,
                          input logic eo, input string name, output int unsigned t0);
        wait_idle();
        bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        bus.start = 1'b0;
        if (push) push_exp(es, ec, eo, t0 + W, name);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (bus.done === 1'b1) begin
            tests++;
            if (prev_done === 1'b1) begin
                fails++;
                $display("FAIL done_pulse: done high on consecutive cycles at cyc %0d, required single pulse", cyc);
            end
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: done at cyc %0d with nothing pending, required no done", cyc);
            end else begin
                e = q.pop_front();
                ok = (bus.sum === e.sum) && (bus.carry === e.carry) && (cyc == e.cyc);
`ifdef SERIAL_ADDER_OVF_EN
                ok = ok && (bus.ovf === e.ovf);
                if (!ok) begin
                    fails++;
                    $display("FAIL %s: got sum=%0h carry=%0b ovf=%0b cyc=%0d, required sum=%0h carry=%0b ovf=%0b cyc=%0d",
                             e.name, bus.sum, bus.carry, bus.ovf, cyc, e.sum, e.carry, e.ovf, e.cyc);
                end
`else
                if (!ok) begin
                    fails++;
                    $display("FAIL %s: got sum=%0h carry=%0b cyc=%0d, required sum=%0h carry=%0b cyc=%0d",
                             e.name, bus.sum, bus.carry, cyc, e.sum, e.carry, e.cyc);
                end
`endif
            end
        end
        prev_done = bus.done;
    end

    initial begin
        int unsigned t0;
        int unsigned n;
        logic [W-1:0] ra, rb, rs;
        logic         rc, rco;

        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_sum", 32'(bus.sum), 32'd0);
        check("reset_carry", 32'(bus.carry), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset_ovf", 32'(bus.ovf), 32'd0);
`endif
        rst_n = 1'b1;

        // Basic add plus busy window length
        launch(8'h0F, 8'h01, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, "add_0f_01", t0);
        n = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, 32'd9);

        launch(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, "add_ff_01", t0);
        launch(8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, "add_ff_ff_c1", t0);

        // start held high; operands change mid-op, second op starts only from IDLE
        wait_idle();
        bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        push_exp(8'h46, 1'b0, 1'b0, t0 + W, "held_first");
        repeat (2) @(posedge clk);
        #1;
        bus.a = 8'hAA; bus.b = 8'h55;
        repeat (8) @(posedge clk);
        #1;
        bus.start = 1'b0;
        push_exp(8'hFF, 1'b0, 1'b0, t0 + W + 2 + W, "held_second");

        // Reset asserted for one edge during the 4th SHIFT cycle
        launch(8'h21, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "abort", t0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_carry", 32'(bus.carry), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("abort_ovf", 32'(bus.ovf), 32'd0);
`endif
        repeat (W + 4) @(posedge clk);
        #1;
        check("abort_stays_idle", 32'(bus.busy), 32'd0);

        launch(8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, "ovf_7f_01", t0);
        launch(8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, "ovf_80_80", t0);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(1, 0));
            {rco, rs} = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            launch(ra, rb, rc, 1'b1, rs, rco, signed_ovf(ra, rb, rs), "random", t0);
        end

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
